// File: rtl/ibuf_prefetch_ctrl.sv
// ibuf_prefetch_ctrl
//   Prefetch queue controller for the 16x16-bit instruction buffer RAM. It fetches
//   16-bit code words from the memory bus into a 16-word ring, and tracks a
//   byte-granular read pointer for the decoder. It also drives the buffer's
//   pair-select read address. A flush discards the queue and restarts fetching at
//   a new, possibly byte-odd, physical address.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   flush        in   discard queue, restart fetch at flush_addr
//   flush_addr   in   new physical fetch address (may be odd)
//   mem_req      out  fetch request, held until mem_ack
//   mem_addr     out  word-aligned fetch address
//   mem_ack      in   one-cycle acknowledge, mem_data valid
//   mem_data     in   fetched code word (little-endian)
//   ibuf_data    out  buffer write data
//   ibuf_waddr   out  buffer write word index
//   ibuf_we      out  buffer write enable
//   ibuf_raddr   out  buffer read pair index (4-byte window)
//   byte_offset  out  first valid byte of the current buffer q window
//   avail_bytes  out  bytes readable by the decoder, 0..32
//   consume      in   bytes retired this cycle, 0..4
module ibuf_prefetch_ctrl #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned QWORDS_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_addr,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [15:0]            mem_data,
  output logic [15:0]            ibuf_data,
  output logic [QWORDS_LOG2-1:0] ibuf_waddr,
  output logic                   ibuf_we,
  output logic [QWORDS_LOG2-2:0] ibuf_raddr,
  output logic [1:0]             byte_offset,
  output logic [QWORDS_LOG2+1:0] avail_bytes,
  input  logic [2:0]             consume
);

  // Word pointer and byte pointer, each carrying one extra wrap bit.
  localparam int unsigned WpW = QWORDS_LOG2 + 1;
  localparam int unsigned RpW = QWORDS_LOG2 + 2;

  typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

  state_e r_state, w_state_next;

  logic [WpW-1:0]    r_wr_ptr, w_wr_ptr_next;
  logic [WpW-1:0]    r_wr_ptr_d, w_wr_ptr_d_next;
  logic [RpW-1:0]    r_rd_ptr, w_rd_ptr_next;
  logic [RpW-1:0]    r_avail, w_avail_next, w_avail_diff;
  logic [ADDR_W-1:0] r_fetch_addr, w_fetch_addr_next;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_next;

  logic [WpW-1:0] w_used_words;
  logic           w_full;
  logic           w_ack_write;
  logic [RpW-1:0] w_consume_ext;
  logic [RpW-1:0] w_take;

  assign w_used_words  = r_wr_ptr - r_rd_ptr[RpW-1:1];
  assign w_full        = (w_used_words == {1'b1, {QWORDS_LOG2{1'b0}}});
  // A flush or reset in the ack cycle drops the returned word.
  assign w_ack_write   = (r_state == StFetch) && mem_ack && !flush && !reset;
  assign w_consume_ext = {{(RpW-3){1'b0}}, consume};
  assign w_take        = (w_consume_ext > r_avail) ? r_avail : w_consume_ext;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (!flush && !w_full) w_state_next = StFetch;
      end
      StFetch: begin
        // The bus transaction cannot be aborted; a flush without ack waits it out.
        if (mem_ack)    w_state_next = StIdle;
        else if (flush) w_state_next = StDiscard;
      end
      StDiscard: begin
        if (mem_ack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req     = (r_state != StIdle);
    mem_addr    = r_req_addr;
    ibuf_we     = w_ack_write;
    ibuf_waddr  = r_wr_ptr[QWORDS_LOG2-1:0];
    ibuf_data   = mem_data;
    // The buffer samples the pointer it will hold after this edge, so q and
    // byte_offset describe the same pointer in the following cycle.
    ibuf_raddr  = w_rd_ptr_next[RpW-2:2];
    byte_offset = r_rd_ptr[1:0];
    avail_bytes = r_avail;
  end

  // ---------------------------------------------------------------------------
  // Pointer / address datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wr_ptr_next     = r_wr_ptr;
    w_rd_ptr_next     = r_rd_ptr + w_take;
    w_fetch_addr_next = r_fetch_addr;
    w_req_addr_next   = r_req_addr;
    w_wr_ptr_d_next   = r_wr_ptr;

    if (r_state == StIdle && w_state_next == StFetch) begin
      w_req_addr_next = r_fetch_addr;
    end

    if (w_ack_write) begin
      w_wr_ptr_next     = r_wr_ptr + {{(WpW-1){1'b0}}, 1'b1};
      w_fetch_addr_next = r_fetch_addr + {{(ADDR_W-2){1'b0}}, 2'd2};
    end

    if (flush) begin
      w_wr_ptr_next     = '0;
      w_wr_ptr_d_next   = '0;
      w_rd_ptr_next     = {{(RpW-1){1'b0}}, flush_addr[0]};
      w_fetch_addr_next = {flush_addr[ADDR_W-1:1], 1'b0};
    end

    if (reset) begin
      w_wr_ptr_next     = '0;
      w_wr_ptr_d_next   = '0;
      w_rd_ptr_next     = '0;
      w_fetch_addr_next = '0;
      w_req_addr_next   = '0;
    end

    // Counting only words the buffer can already return. After an odd flush the
    // read pointer sits one byte ahead of the empty queue; that transient
    // "negative" difference reads as zero.
    w_avail_diff = {w_wr_ptr_d_next, 1'b0} - w_rd_ptr_next;
    if (flush || reset || (w_avail_diff > {1'b1, {(RpW-1){1'b0}}})) begin
      w_avail_next = '0;
    end else begin
      w_avail_next = w_avail_diff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_wr_ptr_d   <= '0;
      r_rd_ptr     <= '0;
      r_avail      <= '0;
      r_fetch_addr <= '0;
      r_req_addr   <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_next;
      r_wr_ptr_d   <= w_wr_ptr_d_next;
      r_rd_ptr     <= w_rd_ptr_next;
      r_avail      <= w_avail_next;
      r_fetch_addr <= w_fetch_addr_next;
      r_req_addr   <= w_req_addr_next;
    end
  end

endmodule

// File: tb/tb_ibuf_prefetch_ctrl.sv
// Self-checking bench for ibuf_prefetch_ctrl. Expected buffer writes go into a
// scoreboard queue when the bench acks a fetch; a monitor pops and compares on
// every ibuf_we. Scenario tasks check bus addresses and pointer outputs inline.
module tb_ibuf_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [19:0] flush_addr;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] ibuf_data;
  logic [3:0]  ibuf_waddr;
  logic        ibuf_we;
  logic [2:0]  ibuf_raddr;
  logic [1:0]  byte_offset;
  logic [5:0]  avail_bytes;
  logic [2:0]  consume;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  waddr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;

  always #5 clk = ~clk;

  ibuf_prefetch_ctrl #(
    .ADDR_W      (20),
    .QWORDS_LOG2 (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .ibuf_data   (ibuf_data),
    .ibuf_waddr  (ibuf_waddr),
    .ibuf_we     (ibuf_we),
    .ibuf_raddr  (ibuf_raddr),
    .byte_offset (byte_offset),
    .avail_bytes (avail_bytes),
    .consume     (consume)
  );

  // Scoreboard monitor: every buffer write must match the oldest expected one.
  always @(negedge clk) begin
    if (ibuf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got waddr=%0d data=%h want no write",
                 ibuf_waddr, ibuf_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({ibuf_waddr, ibuf_data} !== mon_exp) begin
          failures++;
          $display("FAIL sb_write got waddr=%0d data=%h want waddr=%0d data=%h",
                   ibuf_waddr, ibuf_data, mon_exp.waddr, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus responder: waits (bounded) for a request, acks after 'delay' cycles.
  task automatic fetch_word(input int delay, input logic [15:0] data, input bit expect_wr,
                            input logic [3:0] exp_waddr, output logic [19:0] addr,
                            output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    addr = mem_addr;
    repeat (delay) tick();
    mem_ack  = 1'b1;
    mem_data = data;
    if (expect_wr) exp_q.push_back({exp_waddr, data});
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; flush_addr = '0; mem_ack = 1'b0; mem_data = '0; consume = '0;
    tick(); tick();
    checks++;
    if ({mem_req, ibuf_we, avail_bytes, byte_offset, ibuf_raddr} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b we=%b avail=%0d off=%0d raddr=%0d want all 0",
               mem_req, ibuf_we, avail_bytes, byte_offset, ibuf_raddr);
    end
  endtask

  task automatic test_fill();
    logic [19:0] a;
    bit ok;
    int reqs;
    reset = 1'b0; flush = 1'b1; flush_addr = 20'h01000;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 16; k++) begin
      fetch_word(0, 16'h1111 * k[15:0], 1'b1, k[3:0], a, ok);
      checks++;
      if (!ok || a !== 20'h01000 + 20'(2 * k)) begin
        failures++;
        $display("FAIL fill_addr k=%0d got=%h ok=%0d want=%h", k, a, ok, 20'h01000 + 20'(2 * k));
      end
    end
    checks++;
    if (avail_bytes !== 6'd30) begin
      failures++;
      $display("FAIL fill_avail_lag got=%0d want=30", avail_bytes);
    end
    tick();
    checks++;
    if (avail_bytes !== 6'd32) begin
      failures++;
      $display("FAIL fill_avail_full got=%0d want=32", avail_bytes);
    end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b0) reqs++;
      tick();
    end
    checks++;
    if (reqs != 0) begin
      failures++;
      $display("FAIL fill_stop got req_cycles=%0d want=0", reqs);
    end
  endtask

  task automatic test_full_consume();
    logic [19:0] a;
    bit ok;
    int reqs;
    checks++;
    if (ibuf_raddr !== 3'd0) begin
      failures++;
      $display("FAIL full_raddr_idle got=%0d want=0", ibuf_raddr);
    end
    consume = 3'd4;
    #1;
    checks++;
    if (ibuf_raddr !== 3'd1) begin
      failures++;
      $display("FAIL full_raddr_next got=%0d want=1", ibuf_raddr);
    end
    tick();
    consume = 3'd0;
    checks++;
    if (avail_bytes !== 6'd28 || byte_offset !== 2'd0) begin
      failures++;
      $display("FAIL full_after_consume got avail=%0d off=%0d want avail=28 off=0",
               avail_bytes, byte_offset);
    end
    fetch_word(1, 16'hA0A0, 1'b1, 4'd0, a, ok);
    checks++;
    if (!ok || a !== 20'h01020) begin
      failures++;
      $display("FAIL wrap_fetch0 got=%h ok=%0d want=01020", a, ok);
    end
    fetch_word(1, 16'hA1A1, 1'b1, 4'd1, a, ok);
    checks++;
    if (!ok || a !== 20'h01022) begin
      failures++;
      $display("FAIL wrap_fetch1 got=%h ok=%0d want=01022", a, ok);
    end
    tick();
    checks++;
    if (avail_bytes !== 6'd32) begin
      failures++;
      $display("FAIL wrap_avail got=%0d want=32", avail_bytes);
    end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b0) reqs++;
      tick();
    end
    checks++;
    if (reqs != 0) begin
      failures++;
      $display("FAIL wrap_refull got req_cycles=%0d want=0", reqs);
    end
  endtask

  task automatic test_odd_flush();
    logic [19:0] a;
    bit ok;
    flush = 1'b1; flush_addr = 20'h01003;
    tick();
    flush = 1'b0;
    checks++;
    if (byte_offset !== 2'd1 || avail_bytes !== 6'd0) begin
      failures++;
      $display("FAIL odd_flush_state got off=%0d avail=%0d want off=1 avail=0",
               byte_offset, avail_bytes);
    end
    fetch_word(1, 16'hBBAA, 1'b1, 4'd0, a, ok);
    checks++;
    if (!ok || a !== 20'h01002) begin
      failures++;
      $display("FAIL odd_first_addr got=%h ok=%0d want=01002", a, ok);
    end
    checks++;
    if (avail_bytes !== 6'd0) begin
      failures++;
      $display("FAIL odd_avail_hidden got=%0d want=0", avail_bytes);
    end
    tick();
    checks++;
    if (avail_bytes !== 6'd1) begin
      failures++;
      $display("FAIL odd_avail_first got=%0d want=1", avail_bytes);
    end
    fetch_word(1, 16'hDDCC, 1'b1, 4'd1, a, ok);
    checks++;
    if (!ok || a !== 20'h01004) begin
      failures++;
      $display("FAIL odd_second_addr got=%h ok=%0d want=01004", a, ok);
    end
    tick();
    checks++;
    if (avail_bytes !== 6'd3) begin
      failures++;
      $display("FAIL odd_avail_second got=%0d want=3", avail_bytes);
    end
  endtask

  task automatic test_flush_pending();
    logic [19:0] a;
    bit ok;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 20'h01006) begin
      failures++;
      $display("FAIL pend_req got req=%b addr=%h want req=1 addr=01006", mem_req, mem_addr);
    end
    flush = 1'b1; flush_addr = 20'h02000;
    tick();
    flush = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 20'h01006 || avail_bytes !== 6'd0) begin
      failures++;
      $display("FAIL discard_hold got req=%b addr=%h avail=%0d want req=1 addr=01006 avail=0",
               mem_req, mem_addr, avail_bytes);
    end
    tick(); tick();
    mem_ack = 1'b1; mem_data = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (ibuf_we !== 1'b0) begin
      failures++;
      $display("FAIL discard_we got=%b want=0", ibuf_we);
    end
    tick();
    mem_ack = 1'b0;
    fetch_word(0, 16'h1234, 1'b1, 4'd0, a, ok);
    checks++;
    if (!ok || a !== 20'h02000) begin
      failures++;
      $display("FAIL discard_next_addr got=%h ok=%0d want=02000", a, ok);
    end
  endtask

  task automatic test_flush_ack();
    logic [19:0] a;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok || mem_addr !== 20'h02002) begin
      failures++;
      $display("FAIL fa_req got ok=%0d addr=%h want ok=1 addr=02002", ok, mem_addr);
    end
    mem_ack = 1'b1; mem_data = 16'hBEEF; flush = 1'b1; flush_addr = 20'h03005;
    @(negedge clk);
    checks++;
    if (ibuf_we !== 1'b0) begin
      failures++;
      $display("FAIL fa_we got=%b want=0", ibuf_we);
    end
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    checks++;
    if (avail_bytes !== 6'd0 || byte_offset !== 2'd1) begin
      failures++;
      $display("FAIL fa_state got avail=%0d off=%0d want avail=0 off=1", avail_bytes, byte_offset);
    end
    fetch_word(0, 16'h5566, 1'b1, 4'd0, a, ok);
    checks++;
    if (!ok || a !== 20'h03004) begin
      failures++;
      $display("FAIL fa_next_addr got=%h ok=%0d want=03004", a, ok);
    end
  endtask

  task automatic test_overconsume_reset();
    logic [19:0] a;
    bit ok;
    fetch_word(0, 16'h7788, 1'b1, 4'd1, a, ok);
    checks++;
    if (!ok || a !== 20'h03006) begin
      failures++;
      $display("FAIL oc_fetch_addr got=%h ok=%0d want=03006", a, ok);
    end
    tick();
    checks++;
    if (avail_bytes !== 6'd3) begin
      failures++;
      $display("FAIL oc_avail_before got=%0d want=3", avail_bytes);
    end
    consume = 3'd4;
    #1;
    checks++;
    if (ibuf_raddr !== 3'd1) begin
      failures++;
      $display("FAIL oc_raddr got=%0d want=1", ibuf_raddr);
    end
    tick();
    consume = 3'd0;
    checks++;
    if (avail_bytes !== 6'd0 || byte_offset !== 2'd0) begin
      failures++;
      $display("FAIL oc_clamp got avail=%0d off=%0d want avail=0 off=0", avail_bytes, byte_offset);
    end
    consume = 3'd4;
    tick();
    consume = 3'd0;
    checks++;
    if (avail_bytes !== 6'd0 || byte_offset !== 2'd0) begin
      failures++;
      $display("FAIL oc_empty got avail=%0d off=%0d want avail=0 off=0", avail_bytes, byte_offset);
    end
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_pending got req=%b want=1", mem_req);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({mem_req, ibuf_we, avail_bytes, byte_offset, ibuf_raddr} !== 13'd0) begin
      failures++;
      $display("FAIL rst_mid_fetch got req=%b we=%b avail=%0d off=%0d raddr=%0d want all 0",
               mem_req, ibuf_we, avail_bytes, byte_offset, ibuf_raddr);
    end
    reset = 1'b0; mem_ack = 1'b1; mem_data = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (ibuf_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale_ack got we=%b want=0", ibuf_we);
    end
    tick();
    mem_ack = 1'b0;
    fetch_word(0, 16'h7777, 1'b1, 4'd0, a, ok);
    checks++;
    if (!ok || a !== 20'h00000) begin
      failures++;
      $display("FAIL rst_refetch_addr got=%h ok=%0d want=00000", a, ok);
    end
    tick();
    checks++;
    if (avail_bytes !== 6'd2) begin
      failures++;
      $display("FAIL rst_refetch_avail got=%0d want=2", avail_bytes);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_consume();
    test_odd_flush();
    test_flush_pending();
    test_flush_ack();
    test_overconsume_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
